// File: rtl/adc_result_reader.sv
// ADC read-side sequencer: waits for end-of-conversion, strobes RD for a fixed
// access time, latches the data bus and pulses VALID (or TIMEOUT if INTR_n never arrives).
module adc_result_reader #(
  parameter int DATA_WIDTH      = 8,
  parameter int ACCESS_CYCLES   = 10,
  parameter int RECOVERY_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  START,
  input  logic                  INTR_n,
  input  logic [DATA_WIDTH-1:0] DB,
  output logic                  RD,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  VALID,
  output logic                  TIMEOUT,
  output logic                  BUSY
);

  localparam int MAX_AR  = (ACCESS_CYCLES > RECOVERY_CYCLES) ? ACCESS_CYCLES : RECOVERY_CYCLES;
  localparam int MAX_CYC = (MAX_AR > TIMEOUT_CYCLES) ? MAX_AR : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] C_ACCESS  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_RECOVER = CNT_W'(RECOVERY_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_INTR,
    S_ACCESS,
    S_RECOVER
  } state_t;

  state_t                r_state;
  logic                  r_intr_meta;
  logic                  r_intr_s;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_timeout;
  logic                  r_busy;

  // INTR_n is asynchronous; idle-high reset values avoid a spurious read after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_intr_meta <= 1'b1;
      r_intr_s    <= 1'b1;
    end else begin
      r_intr_meta <= INTR_n;
      r_intr_s    <= r_intr_meta;
    end
  end

  // One counter serves as the INTR_n timeout timer and the access/recovery counter,
  // since those phases never overlap. It is always reloaded on entry to a phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd      <= 1'b1;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rd   <= 1'b1;
          r_busy <= 1'b0;
          if (START) begin
            r_state <= S_WAIT_INTR;
            r_cnt   <= C_TIMEOUT;
            r_busy  <= 1'b1;
          end
        end
        S_WAIT_INTR: begin
          // A late INTR_n on the final timer cycle still wins over the timeout.
          if (!r_intr_s) begin
            r_state <= S_ACCESS;
            r_rd    <= 1'b0;
            r_cnt   <= C_ACCESS;
          end else if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            r_data  <= DB;
            r_valid <= 1'b1;
            r_rd    <= 1'b1;
            r_state <= S_RECOVER;
            r_cnt   <= C_RECOVER;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RECOVER: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rd    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RD      = r_rd;
  assign DATA    = r_data;
  assign VALID   = r_valid;
  assign TIMEOUT = r_timeout;
  assign BUSY    = r_busy;

endmodule

// File: tb/tb_adc_result_reader.sv
// Bench for adc_result_reader: directed scenarios plus randomized reads, all checked
// cycle by cycle against a timestamp-based reference of when each read/timeout happens.
module tb_adc_result_reader;

  localparam int DW = 8;
  localparam int A  = 10;
  localparam int R  = 4;
  localparam int T  = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          START = 1'b0;
  logic          INTR_n = 1'b0;
  logic [DW-1:0] DB = '0;
  logic          RD;
  logic [DW-1:0] DATA;
  logic          VALID;
  logic          TIMEOUT;
  logic          BUSY;

  adc_result_reader #(
    .DATA_WIDTH(DW), .ACCESS_CYCLES(A), .RECOVERY_CYCLES(R), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .START(START), .INTR_n(INTR_n), .DB(DB),
    .RD(RD), .DATA(DATA), .VALID(VALID), .TIMEOUT(TIMEOUT), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string cur_tag = "init";

  // Reference: edge counter plus the edge numbers at which each event is due.
  int  cyc = 0;
  int  wait_k = 0;
  int  rd_start = -100;
  int  busy_end = 0;
  bit  waiting = 0;
  bit  reading = 0;
  logic intr_d1 = 1'b1, intr_d2 = 1'b1, rst_d1 = 1'b1, rst_d2 = 1'b1;
  logic m_rd = 1'b1, m_busy = 1'b0, m_valid = 1'b0, m_timeout = 1'b0;
  logic [DW-1:0] m_data = '0;

  int rd_low_obs, valid_obs, to_obs;

  task automatic model_step();
    logic intr_seen;
    cyc++;
    // What the FSM sees this edge: INTR_n from two edges ago, forced high around reset.
    intr_seen = (rst_d1 || rst_d2) ? 1'b1 : intr_d2;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    if (rst) begin
      waiting  = 0;
      reading  = 0;
      busy_end = cyc;
      m_data   = '0;
    end else begin
      if (waiting) begin
        if (!intr_seen) begin
          waiting  = 0;
          reading  = 1;
          rd_start = cyc;
          busy_end = cyc + A + R;
        end else if (cyc == wait_k + T) begin
          waiting   = 0;
          busy_end  = cyc;
          m_timeout = 1'b1;
        end
      end else if (cyc > busy_end && START) begin
        waiting = 1;
        wait_k  = cyc;
      end
      if (reading && cyc == rd_start + A) begin
        m_valid = 1'b1;
        m_data  = DB;
      end
    end
    m_rd   = !(reading && cyc >= rd_start && cyc < rd_start + A);
    m_busy = waiting || (cyc < busy_end);
    intr_d2 = intr_d1;
    intr_d1 = INTR_n;
    rst_d2  = rst_d1;
    rst_d1  = rst;
  endtask

  task automatic check_outputs();
    checks += 5;
    assert (RD === m_rd) else begin
      errors++; $error("FAIL %s RD cyc %0d observed %b expected %b", cur_tag, cyc, RD, m_rd);
    end
    assert (BUSY === m_busy) else begin
      errors++; $error("FAIL %s BUSY cyc %0d observed %b expected %b", cur_tag, cyc, BUSY, m_busy);
    end
    assert (VALID === m_valid) else begin
      errors++; $error("FAIL %s VALID cyc %0d observed %b expected %b", cur_tag, cyc, VALID, m_valid);
    end
    assert (TIMEOUT === m_timeout) else begin
      errors++; $error("FAIL %s TIMEOUT cyc %0d observed %b expected %b", cur_tag, cyc, TIMEOUT, m_timeout);
    end
    assert (DATA === m_data) else begin
      errors++; $error("FAIL %s DATA cyc %0d observed %h expected %h", cur_tag, cyc, DATA, m_data);
    end
    if (RD === 1'b0) rd_low_obs++;
    if (VALID === 1'b1) valid_obs++;
    if (TIMEOUT === 1'b1) to_obs++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic expect_cnt(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++; $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_val(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    rd_low_obs = 0;
    valid_obs  = 0;
    to_obs     = 0;
  endtask

  task automatic run_to_idle(int max_cycles, bit rand_inputs);
    for (int k = 0; k < max_cycles && m_busy; k++) begin
      if (rand_inputs) begin
        DB    = DW'($urandom);
        START = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    START = 1'b0;
    checks++;
    assert (BUSY === 1'b0) else begin
      errors++; $error("FAIL %s idle_bound BUSY observed %b expected 0", cur_tag, BUSY);
    end
  endtask

  initial begin
    clear_obs();

    // 1: reset with START and INTR_n active
    cur_tag = "reset";
    rst = 1'b1; START = 1'b1; INTR_n = 1'b0;
    repeat (3) tick();
    rst = 1'b0; START = 1'b0; INTR_n = 1'b1;
    tick();
    expect_val("reset_data", DATA, 8'h00);
    repeat (3) tick();
    $display("txn reset done cyc %0d", cyc);

    // 2: basic read, INTR_n falls 5 cycles after START
    cur_tag = "basic"; clear_obs();
    DB = 8'hA5; START = 1'b1; tick(); START = 1'b0;
    repeat (4) tick();
    INTR_n = 1'b0;
    run_to_idle(40, 0);
    INTR_n = 1'b1;
    expect_cnt("basic_rd_low", rd_low_obs, A);
    expect_cnt("basic_valid", valid_obs, 1);
    expect_val("basic_data", DATA, 8'hA5);
    $display("txn basic data %h", DATA);
    repeat (3) tick();

    // 3: timeout with INTR_n held high
    cur_tag = "timeout"; clear_obs();
    START = 1'b1; tick(); START = 1'b0;
    run_to_idle(T + 10, 0);
    expect_cnt("timeout_pulses", to_obs, 1);
    expect_cnt("timeout_rd_low", rd_low_obs, 0);
    expect_val("timeout_data", DATA, 8'hA5);
    $display("txn timeout data %h", DATA);

    // 4: START during ACCESS and RECOVER is ignored, then a new read after idle
    cur_tag = "ignore_start"; clear_obs();
    INTR_n = 1'b0; DB = 8'h5A;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      START = (i == 0 || i == 5 || i == 13);
      tick();
    end
    START = 1'b0;
    expect_cnt("ignore_rd_low", rd_low_obs, A);
    expect_cnt("ignore_valid", valid_obs, 1);
    clear_obs();
    DB = 8'h96; START = 1'b1; tick(); START = 1'b0;
    run_to_idle(30, 0);
    expect_cnt("restart_valid", valid_obs, 1);
    expect_val("restart_data", DATA, 8'h96);
    $display("txn ignore_start data %h", DATA);

    // back-to-back reads with START held
    cur_tag = "held_start"; clear_obs();
    START = 1'b1;
    repeat (40) tick();
    START = 1'b0;
    run_to_idle(30, 0);
    expect_cnt("held_valid", valid_obs, 3);
    $display("txn held_start valids %0d", valid_obs);

    // 5: reset on the 4th ACCESS cycle
    cur_tag = "reset_access"; clear_obs();
    DB = 8'h77; START = 1'b1; tick(); START = 1'b0;
    for (int k = 0; k < 20 && !(reading && cyc == rd_start + 3); k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    assert (RD === 1'b1) else begin
      errors++; $error("FAIL reset_access_rd observed %b expected 1", RD);
    end
    expect_val("reset_access_data", DATA, 8'h00);
    repeat (15) tick();
    expect_cnt("reset_access_valid", valid_obs, 0);
    INTR_n = 1'b1; repeat (3) tick();
    clear_obs();
    DB = 8'h81; START = 1'b1; tick(); START = 1'b0;
    repeat (3) tick();
    INTR_n = 1'b0;
    run_to_idle(40, 0);
    expect_val("after_reset_data", DATA, 8'h81);
    expect_cnt("after_reset_valid", valid_obs, 1);
    $display("txn reset_access data %h", DATA);

    // 6: DB changes on the last access cycle only
    cur_tag = "db_late"; clear_obs();
    DB = 8'h3C; START = 1'b1; tick(); START = 1'b0;
    for (int k = 0; k < 40 && m_busy; k++) begin
      DB = (reading && cyc + 1 == rd_start + A) ? 8'hC3 : 8'h3C;
      tick();
    end
    expect_val("db_late_data", DATA, 8'hC3);
    $display("txn db_late data %h", DATA);
    INTR_n = 1'b1;

    // randomized reads with random INTR_n delay (some beyond the timeout)
    for (int t = 0; t < 20; t++) begin
      int d;
      cur_tag = "random"; clear_obs();
      INTR_n = 1'b1; START = 1'b0;
      repeat ($urandom_range(3, 6)) begin DB = DW'($urandom); tick(); end
      START = 1'b1; DB = DW'($urandom); tick(); START = 1'b0;
      d = $urandom_range(0, 60);
      for (int k = 0; k < d && m_busy; k++) begin DB = DW'($urandom); tick(); end
      INTR_n = 1'b0;
      run_to_idle(40, 1);
      $display("txn random %0d delay %0d valid %0d timeout %0d data %h", t, d, valid_obs, to_obs, DATA);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_result_reader.md
Name: adc_result_reader

Overview:
Read-side companion to the ADC conversion-start block. After a conversion is started, this block waits for the ADC's active-low end-of-conversion line (INTR_n) and drives the active-low read strobe (RD) for a fixed access time. It latches the ADC's parallel data bus and presents the sample with a one-cycle VALID pulse. It sits between the ADC pins and the sample-processing logic, and is triggered by the same controller that issues CONVERT.

Parameters:
DATA_WIDTH, 8, width of ADC data bus and DATA output
ACCESS_CYCLES, 10, clk cycles RD is held low before DB is sampled (>=1)
RECOVERY_CYCLES, 4, clk cycles RD is held high after a read before BUSY drops (>=1)
TIMEOUT_CYCLES, 5000, max clk cycles spent waiting for INTR_n before aborting (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
START  input  1  request one read; sampled only in IDLE
INTR_n  input  1  ADC end-of-conversion, active low, asynchronous to clk
DB  input  DATA_WIDTH  ADC parallel data bus
RD  output  1  ADC read strobe, active low, registered
DATA  output  DATA_WIDTH  last successfully read sample, registered
VALID  output  1  one-cycle pulse when DATA updates
TIMEOUT  output  1  one-cycle pulse when the wait for INTR_n expires
BUSY  output  1  high from the cycle after START is accepted until return to IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset values: RD=1, DATA=0, VALID=0, TIMEOUT=0, BUSY=0, state=IDLE, both INTR_n sync flops=1, counters=0.
- INTR_n passes through a 2-flop synchronizer; intr_s is the second stage (2-cycle latency). Only intr_s is used by the FSM.
- Counters are sized by clog2 of the largest cycle parameter. No arithmetic wraps: every counter is reloaded before use and stops at 0.
- FSM states: IDLE, WAIT_INTR, ACCESS, RECOVER.
- IDLE: RD=1, BUSY=0. If START=1 at edge N: go to WAIT_INTR, load timer=TIMEOUT_CYCLES-1, BUSY=1 from N.
- WAIT_INTR:
  - intr_s=0: go to ACCESS, RD<=0 on the same edge, load cnt=ACCESS_CYCLES-1.
  - intr_s=1 and timer=0: go to IDLE, TIMEOUT<=1 for one cycle, BUSY<=0. DATA is unchanged and RD is never asserted.
  - Otherwise, decrement timer.
  - If intr_s=0 on the same cycle timer reaches 0, the read proceeds and no timeout is reported.
- ACCESS: RD stays 0 for exactly ACCESS_CYCLES cycles. On the edge where cnt=0: DATA<=DB, VALID<=1 (one cycle), RD<=1, go to RECOVER, load cnt=RECOVERY_CYCLES-1. Otherwise decrement cnt. DB is sampled only on that final edge.
- RECOVER: RD=1, BUSY=1. Decrement cnt; at cnt=0 go to IDLE with BUSY<=0 on that edge.
- Latency, with intr_s already low: START at edge N gives RD falling at N+1, RD rising plus VALID/DATA at N+1+ACCESS_CYCLES, and BUSY falling at N+1+ACCESS_CYCLES+RECOVERY_CYCLES.
- START while BUSY=1 is ignored, not queued. START held high causes back-to-back reads, each starting on the first IDLE cycle.
- A stale low intr_s when START arrives starts the read immediately. Sequencing CONVERT before START is the caller's job.
- VALID and TIMEOUT are never high in the same cycle.
- rst during any state: next edge forces the reset values above. RD returns high one cycle after rst is sampled, no VALID is produced, and DATA is cleared.

Test Plan:
(Bench parameters: ACCESS_CYCLES=10, RECOVERY_CYCLES=4, TIMEOUT_CYCLES=50, DATA_WIDTH=8.)
1. Assert rst for 3 cycles with INTR_n=0, START=1 -> RD=1, DATA=0x00, VALID=0, TIMEOUT=0, BUSY=0 throughout reset and on the first cycle after release.
2. START pulse; INTR_n low 5 cycles later; DB=0xA5 -> RD low for exactly 10 cycles starting 2-3 cycles after INTR_n falls. DATA=0xA5 with a single VALID pulse on RD's rising edge. BUSY falls 4 cycles later.
3. START pulse; INTR_n held high -> TIMEOUT pulses once 50 cycles after entering WAIT_INTR. RD stays 1, DATA keeps its previous value, BUSY=0 afterwards.
4. START during ACCESS and during RECOVER -> exactly one RD low window and one VALID pulse. A START in IDLE after BUSY falls starts a new read.
5. rst asserted on the 4th ACCESS cycle -> RD=1 the next cycle, no VALID, DATA=0x00. A following START/INTR_n sequence reads normally.
6. DB=0x3C for ACCESS cycles 1-9, switched to 0xC3 on cycle 10 -> DATA=0xC3, confirming DB is sampled only on the final access edge.
